// File: rtl/cpu_sequencer.sv
// cpu_sequencer: 8-phase control sequencer for the RISC CPU datapath and memory
module cpu_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       wr,
    output logic       ld_ir,
    output logic       ld_ac,
    output logic       ld_pc,
    output logic       inc_pc,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
);
    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    phase_e phase_q, phase_d;
    logic   halted_q, halted_d;
    logic   run, alu_op, is_sto, is_jmp, is_skz, is_hlt;

    // Phase and halt-flag registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // Next state: HLT seen in OP_ADDR freezes the counter at phase 4 until reset
    always_comb begin
        halted_d = halted_q | (phase_q == OP_ADDR && opcode == OP_HLT);
        phase_d  = halted_d ? phase_q : phase_e'(phase_q + 3'd1);
    end

    // Opcode decode and control outputs, all gated off once halted
    always_comb begin
        run    = !halted_q;
        alu_op = opcode == OP_ADD || opcode == OP_AND || opcode == OP_XOR || opcode == OP_LDA;
        is_sto = opcode == OP_STO;
        is_jmp = opcode == OP_JMP;
        is_skz = opcode == OP_SKZ;
        is_hlt = opcode == OP_HLT;
        sel    = run && !phase_q[2];
        rd     = run && ((phase_q != INST_ADDR && !phase_q[2]) || (phase_q >= OP_FETCH && alu_op));
        ld_ir  = run && (phase_q == INST_LOAD || phase_q == IDLE);
        ld_ac  = run && phase_q == STORE && alu_op;
        ld_pc  = run && phase_q >= ALU_OP && is_jmp;
        inc_pc = run && (phase_q == OP_ADDR || (phase_q == ALU_OP && is_skz && zero));
        data_e = run && phase_q >= ALU_OP && is_sto;
        wr     = run && phase_q == STORE && is_sto;
        halt   = halted_q || (phase_q == OP_ADDR && is_hlt);
        phase  = phase_q;
    end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: table-driven directed checks of the cpu_sequencer phase/control outputs
module tb_cpu_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
    logic       sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;
    logic [2:0] phase;

    int checks = 0;
    int failures = 0;

    localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND_ = 3'd3;
    localparam logic [2:0] XOR_ = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

    // output bit order: sel rd wr ld_ir ld_ac ld_pc inc_pc data_e halt
    localparam logic [8:0] O_SEL   = 9'b100000000;
    localparam logic [8:0] O_FETCH = 9'b110000000;
    localparam logic [8:0] O_LOAD  = 9'b110100000;
    localparam logic [8:0] O_INC   = 9'b000000100;
    localparam logic [8:0] O_NONE  = 9'b000000000;
    localparam logic [8:0] O_RD    = 9'b010000000;
    localparam logic [8:0] O_RDAC  = 9'b010010000;
    localparam logic [8:0] O_DE    = 9'b000000010;
    localparam logic [8:0] O_WRDE  = 9'b001000010;
    localparam logic [8:0] O_LDPC  = 9'b000001000;
    localparam logic [8:0] O_HLT4  = 9'b000000101;
    localparam logic [8:0] O_HALTD = 9'b000000001;

    typedef struct {
        logic       r;
        logic [2:0] op;
        logic       z;
        logic [2:0] ph;
        logic [8:0] o;
        string      name;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .sel(sel), .rd(rd), .wr(wr), .ld_ir(ld_ir), .ld_ac(ld_ac),
        .ld_pc(ld_pc), .inc_pc(inc_pc), .data_e(data_e), .halt(halt), .phase(phase)
    );

    task automatic add(input logic r, input logic [2:0] op, input logic z,
                       input logic [2:0] ph, input logic [8:0] o, input string name);
        vec_t v;
        v.r = r; v.op = op; v.z = z; v.ph = ph; v.o = o; v.name = name;
        tbl.push_back(v);
    endtask

    // one full instruction starting from phase 0; phases 1-2 carry a junk opcode
    task automatic inst(input logic [2:0] op, input logic z, input logic [8:0] o4,
                        input logic [8:0] o5, input logic [8:0] o6, input logic [8:0] o7,
                        input string name);
        add(1'b0, op ^ 3'd7, z, 3'd1, O_FETCH, {name, "_p1"});
        add(1'b0, op ^ 3'd7, z, 3'd2, O_LOAD,  {name, "_p2"});
        add(1'b0, op, z, 3'd3, O_LOAD, {name, "_p3"});
        add(1'b0, op, z, 3'd4, o4, {name, "_p4"});
        add(1'b0, op, z, 3'd5, o5, {name, "_p5"});
        add(1'b0, op, z, 3'd6, o6, {name, "_p6"});
        add(1'b0, op, z, 3'd7, o7, {name, "_p7"});
        add(1'b0, op, z, 3'd0, O_SEL, {name, "_p0"});
    endtask

    task automatic apply(input vec_t v);
        logic [8:0] act;
        rst = v.r; opcode = v.op; zero = v.z;
        @(posedge clk);
        #1;
        act = {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt};
        checks++;
        if (phase !== v.ph) begin
            failures++;
            $display("FAIL %s phase: got %0d expected %0d", v.name, phase, v.ph);
        end
        checks++;
        if (act !== v.o) begin
            failures++;
            $display("FAIL %s outputs: got %b expected %b", v.name, act, v.o);
        end
        checks++;
        if ((rd && wr) || (ld_pc && inc_pc)) begin
            failures++;
            $display("FAIL %s exclusion: rd=%b wr=%b ld_pc=%b inc_pc=%b", v.name, rd, wr, ld_pc, inc_pc);
        end
    endtask

    task automatic step(input logic r, input logic [2:0] op, input logic z,
                        input logic [2:0] ph, input logic [8:0] o, input string name);
        vec_t v;
        v.r = r; v.op = op; v.z = z; v.ph = ph; v.o = o; v.name = name;
        apply(v);
    endtask

    initial begin
        add(1'b1, ADD, 1'b0, 3'd0, O_SEL, "reset0");
        add(1'b1, STO, 1'b1, 3'd0, O_SEL, "reset1");
        inst(ADD,  1'b0, O_INC, O_RD,   O_RD,   O_RDAC, "add");
        inst(AND_, 1'b1, O_INC, O_RD,   O_RD,   O_RDAC, "and");
        inst(XOR_, 1'b0, O_INC, O_RD,   O_RD,   O_RDAC, "xor");
        inst(LDA,  1'b1, O_INC, O_RD,   O_RD,   O_RDAC, "lda");
        inst(STO,  1'b1, O_INC, O_NONE, O_DE,   O_WRDE, "sto");
        inst(SKZ,  1'b1, O_INC, O_NONE, O_INC,  O_NONE, "skz1");
        inst(SKZ,  1'b0, O_INC, O_NONE, O_NONE, O_NONE, "skz0");
        inst(JMP,  1'b1, O_INC, O_NONE, O_LDPC, O_LDPC, "jmp");
        foreach (tbl[i]) apply(tbl[i]);

        step(1'b0, HLT, 1'b0, 3'd1, O_FETCH, "hlt_p1");
        step(1'b0, HLT, 1'b0, 3'd2, O_LOAD,  "hlt_p2");
        step(1'b0, HLT, 1'b0, 3'd3, O_LOAD,  "hlt_p3");
        step(1'b0, HLT, 1'b0, 3'd4, O_HLT4,  "hlt_p4");
        for (int i = 0; i < 20; i++)
            step(1'b0, (i < 10) ? HLT : ADD, i[0], 3'd4, O_HALTD, "halted");
        step(1'b1, ADD, 1'b0, 3'd0, O_SEL,   "hlt_reset");
        step(1'b0, ADD, 1'b0, 3'd1, O_FETCH, "after_hlt_p1");
        step(1'b0, STO, 1'b0, 3'd2, O_LOAD,  "mid_p2");
        step(1'b0, STO, 1'b0, 3'd3, O_LOAD,  "mid_p3");
        step(1'b0, STO, 1'b0, 3'd4, O_INC,   "mid_p4");
        step(1'b0, STO, 1'b0, 3'd5, O_NONE,  "mid_p5");
        step(1'b0, STO, 1'b0, 3'd6, O_DE,    "mid_p6");
        step(1'b1, STO, 1'b0, 3'd0, O_SEL,   "mid_reset");
        step(1'b0, STO, 1'b0, 3'd1, O_FETCH, "mid_after_p1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
